// File: rtl/mem_pkg.sv
// Shared definitions for the handshaked data memory.
// Contents:
//   - load encodings (LoadLb..LoadLw)
//   - store encodings (StoreSb/StoreSh/StoreSw)
//   - FSM state enum
//   - alignment, type-legality and store-mask helpers
package mem_pkg;

    localparam logic [2:0] LoadLb  = 3'b000;
    localparam logic [2:0] LoadLbu = 3'b001;
    localparam logic [2:0] LoadLh  = 3'b010;
    localparam logic [2:0] LoadLhu = 3'b011;
    localparam logic [2:0] LoadLw  = 3'b100;

    localparam logic [1:0] StoreSb = 2'b00;
    localparam logic [1:0] StoreSh = 2'b01;
    localparam logic [1:0] StoreSw = 2'b10;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // True when a halfword access is odd or a word access is not 4-byte aligned.
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] load_type,
                                           input logic [1:0] store_type,
                                           input logic [1:0] addr_lo);
        logic half;
        logic word;
        if (we) begin
            half = (store_type == StoreSh);
            word = (store_type == StoreSw);
        end else begin
            half = (load_type == LoadLh) || (load_type == LoadLhu);
            word = (load_type == LoadLw);
        end
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

    function automatic logic is_illegal_type(input logic       we,
                                             input logic [2:0] load_type,
                                             input logic [1:0] store_type);
        return we ? (store_type == 2'b11) : (load_type > LoadLw);
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] store_type);
        logic [3:0] mask;
        case (store_type)
            StoreSb: mask = 4'b0001;
            StoreSh: mask = 4'b0011;
            StoreSw: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bundle of the data memory.
// Request channel : req_valid_i, req_ready_o, req_we_i, req_addr_i, req_wdata_i,
//                   req_load_type_i, req_store_type_i
// Response channel: resp_valid_o, resp_ready_i, resp_rdata_o, resp_err_o
// Status          : busy_o
// Signal suffixes are from the memory's point of view (slave modport).
interface data_mem_hs_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic [2:0]        req_load_type_i;
    logic [1:0]        req_store_type_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_load_type_i,
               req_store_type_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_load_type_i,
               req_store_type_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );
endinterface

// File: rtl/dmem_byte_array.sv
// Raw byte storage for the data memory; no formatting, no control.
// Ports:
//   clk     : clock, writes on rising edge
//   we_mask : per-byte write enable, bit i writes wdata[8i+:8] to waddr+i
//   waddr   : write base address
//   wdata   : write data, little-endian lanes
//   raddr   : read base address
//   rdata   : bytes raddr..raddr+3, byte 0 in bits [7:0] (asynchronous read)
module dmem_byte_array #(
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [3:0]        we_mask,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [7:0] mem [Depth];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_mask[i]) begin
                mem[waddr + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with valid/ready request and response channels
// and a fixed access latency of LATENCY cycles (1..15).
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : data_mem_hs_if slave modport (request, response, busy_o)
// Illegal or misaligned requests skip the access and answer the cycle after
// accept with resp_err_o=1 and zero data.
module data_mem_hs import mem_pkg::*; #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_hs_if.slave   bus
);
    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        stype_q, stype_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [3:0]        wr_mask;
    logic [31:0]       raw;
    logic              req_err;

    function automatic logic [31:0] format_load(input logic [2:0] lt, input logic [31:0] b);
        logic [31:0] r;
        case (lt)
            LoadLb:  r = {{24{b[7]}}, b[7:0]};
            LoadLbu: r = {24'h0, b[7:0]};
            LoadLh:  r = {{16{b[15]}}, b[15:0]};
            LoadLhu: r = {16'h0, b[15:0]};
            LoadLw:  r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign req_err = is_misaligned(bus.req_we_i, bus.req_load_type_i, bus.req_store_type_i,
                                   bus.req_addr_i[1:0])
                   | is_illegal_type(bus.req_we_i, bus.req_load_type_i, bus.req_store_type_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ltype_d = ltype_q;
        stype_d = stype_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_mask = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    ltype_d = bus.req_load_type_i;
                    stype_d = bus.req_store_type_i;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                        err_d   = 1'b0;
                    end
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    if (we_q) begin
                        wr_mask = store_mask(stype_q);
                        rdata_d = '0;
                    end else begin
                        rdata_d = format_load(ltype_q, raw);
                    end
                end
            end
            StResp: begin
                if (bus.resp_ready_i) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ltype_q <= '0;
            stype_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ltype_q <= ltype_d;
            stype_q <= stype_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A store due on the same edge as reset is dropped.
    dmem_byte_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .we_mask (rst ? 4'b0000 : wr_mask),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr   (addr_q),
        .rdata   (raw)
    );

    assign bus.req_ready_o  = (state_q == StIdle);
    assign bus.resp_valid_o = (state_q == StResp);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;

endmodule
